// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } FetchQEntry;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            epoch;
  } FetchQTag;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } FetchQState;

endpackage

// File: rtl/fetch_queue_sync_fifo_ptr.sv
// Pointer-based synchronous FIFO with occupancy count and synchronous clear.
module sync_fifo_ptr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem[rd_ptr_q];

  // A push into a full FIFO is accepted when a pop frees the head in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !clr) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue with epoch-based redirect flush.
// Optional performance counters are enabled by defining FETCHQ_PERF_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        deq_in,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_valid_in,
  output logic        busy_out
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_hold_cycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  FetchQState  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        epoch_q, epoch_d;
  logic [CW-1:0] stale_q, stale_d;
  logic        hold_issue_q, hold_issue_d;

  FetchQTag    tag_push, tag_head;
  FetchQEntry  ent_push, ent_head;
  logic        tag_full, tag_empty, ent_full, ent_empty;
  logic [CW-1:0] tag_cnt, ent_cnt;

  logic        credit_c, credit_next_c;
  logic        issue_c, tag_pop_c, accept_c, deq_c, stale_dec_c;
  logic [CW-1:0] ent_next_c, tag_next_c, stale_left_c;

  assign credit_c  = (SW'(ent_cnt) + SW'(tag_cnt)) < SW'(DEPTH);
  assign issue_c   = (state_q == RUN) && credit_c && !redirect_in && !hold_issue_q;
  assign tag_pop_c = mem_valid_in && !tag_empty;
  // Tags issued before the latest redirect are always stale, whatever their epoch bit says.
  assign accept_c  = tag_pop_c && !redirect_in && (stale_q == '0) && (tag_head.epoch == epoch_q);
  assign deq_c     = deq_in && !ent_empty && !redirect_in;

  assign tag_push = '{pc: fetch_pc_q, epoch: epoch_q};
  assign ent_push = '{pc: tag_head.pc, inst: mem_data_in};

  sync_fifo_ptr #(.WIDTH($bits(FetchQTag)), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr       (1'b0),
    .push      (issue_c),
    .push_data (tag_push),
    .pop       (tag_pop_c),
    .head_data (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_cnt)
  );

  sync_fifo_ptr #(.WIDTH($bits(FetchQEntry)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr       (redirect_in),
    .push      (accept_c),
    .push_data (ent_push),
    .pop       (deq_c),
    .head_data (ent_head),
    .full      (ent_full),
    .empty     (ent_empty),
    .count     (ent_cnt)
  );

  assign ent_next_c    = redirect_in ? '0 : (ent_cnt + CW'(accept_c) - CW'(deq_c));
  assign tag_next_c    = tag_cnt + CW'(issue_c) - CW'(tag_pop_c);
  assign credit_next_c = (SW'(ent_next_c) + SW'(tag_next_c)) < SW'(DEPTH);
  assign stale_dec_c   = tag_pop_c && (stale_q != '0);
  assign stale_left_c  = stale_q - CW'(stale_dec_c);

  // Next-state logic: RUN tracks next-cycle credit, stale tags and issue hold after redirect.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q;
    stale_d      = stale_left_c;
    hold_issue_d = hold_issue_q && (stale_left_c != '0);
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!credit_next_c) state_d = HOLD;
      HOLD:    if (credit_next_c)  state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect_in) begin
      fetch_pc_d   = redirect_pc_in;
      epoch_d      = ~epoch_q;
      stale_d      = tag_cnt - CW'(tag_pop_c);
      hold_issue_d = (stale_left_c != '0);
    end else if (issue_c) begin
      fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      epoch_q      <= 1'b0;
      stale_q      <= '0;
      hold_issue_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      stale_q      <= stale_d;
      hold_issue_q <= hold_issue_d;
    end
  end

  assign out_valid    = !ent_empty;
  assign out_pc       = ent_empty ? 32'h0 : ent_head.pc;
  assign out_inst     = ent_empty ? 32'h0 : ent_head.inst;
  assign mem_req_out  = issue_c;
  assign mem_addr_out = issue_c ? fetch_pc_q : 32'h0;
  assign busy_out     = (state_q != RUN) || (tag_cnt != '0);

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_issued      <= 32'h0;
      perf_discarded   <= 32'h0;
      perf_hold_cycles <= 32'h0;
    end else begin
      if (issue_c && (perf_issued != 32'hFFFF_FFFF))
        perf_issued <= perf_issued + 32'h1;
      if (mem_valid_in && !accept_c && (perf_discarded != 32'hFFFF_FFFF))
        perf_discarded <= perf_discarded + 32'h1;
      if ((state_q == HOLD) && (perf_hold_cycles != 32'hFFFF_FFFF))
        perf_hold_cycles <= perf_hold_cycles + 32'h1;
    end
  end
`endif

  // Orphan responses are only expected right after reset, while still in BOOT.
  orphan_resp_a: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (mem_valid_in && (state_q != BOOT)) |-> !tag_empty);
  tag_overflow_a: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    issue_c |-> !tag_full);
  entry_overflow_a: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    accept_c |-> (!ent_full || deq_c));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned PC_STEP  = 4;
  localparam int          LAT      = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        deq_in;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_in;
  logic        mem_valid_in;
  logic        busy_out;
`ifdef FETCHQ_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_discarded;
  logic [31:0] perf_hold_cycles;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .deq_in         (deq_in),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_in    (mem_data_in),
    .mem_valid_in   (mem_valid_in),
    .busy_out       (busy_out)
`ifdef FETCHQ_PERF_EN
    ,
    .perf_issued      (perf_issued),
    .perf_discarded   (perf_discarded),
    .perf_hold_cycles (perf_hold_cycles)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fixed-latency in-order program memory.
  logic        pipe_v [LAT];
  logic [31:0] pipe_a [LAT];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1234;
  endfunction

  task automatic mem_shift(input logic req, input logic [31:0] addr);
    for (int k = LAT - 1; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_a[k] = pipe_a[k-1];
    end
    pipe_v[0] = req;
    pipe_a[0] = addr;
  endtask

  // Reference model: generation numbers stand in for the 1-bit epoch.
  typedef struct { logic [31:0] pc; int gen; } tag_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  tag_t        m_tags[$];
  ent_t        m_ents[$];
  logic        m_boot;
  logic        m_stall;
  logic [31:0] m_pc;
  int          m_gen;
  int          m_issued, m_disc, m_hold;

  task automatic model_reset();
    m_tags.delete();
    m_ents.delete();
    m_boot = 1'b1; m_stall = 1'b0; m_pc = RESET_PC; m_gen = 0;
    m_issued = 0; m_disc = 0; m_hold = 0;
  endtask

  function automatic logic any_old_tags();
    logic r = 1'b0;
    foreach (m_tags[i]) if (m_tags[i].gen < m_gen) r = 1'b1;
    return r;
  endfunction

  task automatic step(input logic rd, input logic [31:0] rpc, input logic dq);
    logic        credit, issue, req_seen;
    logic [31:0] addr_seen;
    tag_t        t;
    redirect_in    = rd;
    redirect_pc_in = rpc;
    deq_in         = dq;
    mem_valid_in   = pipe_v[LAT-1];
    mem_data_in    = pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : 32'h0;
    #1;
    credit = (m_ents.size() + m_tags.size()) < DEPTH;
    issue  = !m_boot && credit && !rd && !m_stall;
    check("mem_req",   32'(mem_req_out), 32'(issue));
    check("mem_addr",  mem_addr_out, issue ? m_pc : 32'h0);
    check("out_valid", 32'(out_valid), 32'(m_ents.size() != 0));
    check("out_pc",    out_pc,   (m_ents.size() != 0) ? m_ents[0].pc   : 32'h0);
    check("out_inst",  out_inst, (m_ents.size() != 0) ? m_ents[0].inst : 32'h0);
    check("busy",      32'(busy_out), 32'(m_boot || !credit || (m_tags.size() != 0)));
`ifdef FETCHQ_PERF_EN
    check("perf_issued",      perf_issued,      32'(m_issued));
    check("perf_discarded",   perf_discarded,   32'(m_disc));
    check("perf_hold_cycles", perf_hold_cycles, 32'(m_hold));
`endif
    req_seen  = mem_req_out;
    addr_seen = mem_addr_out;
    @(posedge clk_in);
    if (!m_boot && !credit) m_hold++;
    if (!rd && dq && (m_ents.size() != 0)) void'(m_ents.pop_front());
    if (mem_valid_in) begin
      if (m_tags.size() != 0) begin
        t = m_tags.pop_front();
        if (!rd && (t.gen == m_gen)) m_ents.push_back('{t.pc, mem_data_in});
        else m_disc++;
      end else begin
        m_disc++;
      end
    end
    if (rd) begin
      m_stall = any_old_tags();
      m_ents.delete();
      m_gen++;
      m_pc = rpc;
    end else begin
      if (m_stall) m_stall = any_old_tags();
      if (issue) begin
        m_tags.push_back('{m_pc, m_gen});
        m_pc += 32'(PC_STEP);
        m_issued++;
      end
    end
    m_boot = 1'b0;
    mem_shift(req_seen, addr_seen);
    @(negedge clk_in);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_pc"},    out_pc,   32'h0);
    check({tag, "_out_inst"},  out_inst, 32'h0);
    check({tag, "_mem_req"},   32'(mem_req_out), 32'h0);
    check({tag, "_mem_addr"},  mem_addr_out, 32'h0);
    check({tag, "_busy"},      32'(busy_out), 32'h1);
  endtask

  // Reset asserted mid-cycle with traffic pending; released at the next falling edge.
  task automatic reset_mid();
    redirect_in  = 1'b0;
    deq_in       = 1'b0;
    mem_valid_in = pipe_v[LAT-1];
    mem_data_in  = pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : 32'h0;
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk_in);
    mem_shift(1'b0, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] rpc;
    rst_n_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0;
    deq_in = 1'b0; mem_valid_in = 1'b0; mem_data_in = 32'h0;
    for (int k = 0; k < LAT; k++) begin pipe_v[k] = 1'b0; pipe_a[k] = 32'h0; end
    model_reset();
    #1 check_reset_outputs("por");
    repeat (3) begin @(posedge clk_in); mem_shift(1'b0, 32'h0); end
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Streaming with decode always consuming.
    repeat (12) step(1'b0, 32'h0, 1'b1);
    // Redirect with responses in flight.
    step(1'b1, 32'h0000_0100, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1);
    // Fill to HOLD, release one slot, then redirect together with dequeue.
    repeat (10) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);
    // PC wrap.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1);
    // Back-to-back redirects with stale tags outstanding.
    step(1'b1, 32'h0000_0400, 1'b1);
    step(1'b1, 32'h0000_0500, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1);
    // Asynchronous reset with entries queued and requests in flight.
    repeat (4) step(1'b0, 32'h0, 1'b0);
    reset_mid();
    repeat (10) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      rpc = r[4] ? {r[31:2], 2'b00} : (32'hFFFF_FFF0 + {28'h0, r[3:2], 2'b00});
      if ($urandom_range(0, 499) == 0) reset_mid();
      else step(($urandom_range(0, 99) < 6), rpc, ($urandom_range(0, 99) < 65));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Prefetch instruction queue between the program memory and the CPU fetch/decode interface.
- Issues sequential instruction reads to a pipelined, fixed-latency, in-order program memory.
- Buffers returned words with their PCs and presents them to decode with a valid/dequeue handshake.
- On redirect, flushes buffered entries and discards in-flight responses using an epoch bit.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16.
RESET_PC, 32'h0, first fetch address after reset.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk_in  input  1  system clock.
rst_n_in  input  1  reset: asynchronous assert, active-low.
redirect_in  input  1  redirect fetch stream; has priority over every other input.
redirect_pc_in  input  32  new fetch PC; used only when redirect_in=1.
deq_in  input  1  decode consumes head entry; ignored when out_valid=0.
out_valid  output  1  head entry valid.
out_pc  output  32  PC of head entry.
out_inst  output  32  instruction word of head entry.
mem_req_out  output  1  read request this cycle.
mem_addr_out  output  32  read address.
mem_data_in  input  32  returned instruction word.
mem_valid_in  input  1  response valid; responses arrive in request order.
busy_out  output  1  requests in flight or state not RUN.

Behaviour:
- Reset values: out_valid=0, out_pc=0, out_inst=0, mem_req_out=0, mem_addr_out=0, busy_out=1. Internal: fetch_pc=RESET_PC, epoch=0, queue empty, in-flight count 0, state BOOT.
- FSM:
  - BOOT: one cycle, then RUN.
  - RUN: issue requests while credit is available; go to HOLD when it is not.
  - HOLD: no requests; return to RUN when credit frees.
- Credit: (queue occupancy + in-flight count) < DEPTH. This guarantees every response has a slot, so no response is ever dropped for lack of space.
- Issue (RUN with credit, combinational same cycle):
  - mem_req_out=1, mem_addr_out=fetch_pc.
  - Push {fetch_pc, epoch} into the in-flight tag FIFO (DEPTH entries).
  - fetch_pc += PC_STEP, modulo 2^32 (wraps 32'hFFFFFFFC -> 0).
- Response (mem_valid_in=1): pop the in-flight tag.
  - Tag epoch == current epoch: enqueue {tag pc, mem_data_in}.
  - Otherwise: discard.
  - mem_valid_in with an empty tag FIFO is illegal (assertion); treat as discard.
- Dequeue: deq_in & out_valid pops the head at the clock edge.
  - Enqueue and dequeue in the same cycle are legal at any occupancy, including full and empty.
  - Empty queue plus arriving response: entry is visible the next cycle. There is no bypass, so latency response -> out_valid is 1 cycle.
- Redirect (redirect_in=1), applied at the clock edge:
  - Queue cleared and out_valid=0 next cycle; a deq_in in the same cycle is ignored.
  - epoch toggles; fetch_pc = redirect_pc_in.
  - No request is issued in the redirect cycle (mem_req_out=0).
  - A response arriving in that cycle is popped and discarded.
  - In-flight count is preserved so stale responses are drained and discarded. Credit therefore counts stale tags until they return.
  - First request to redirect_pc_in is issued the next cycle if credit allows.
  - Back-to-back redirects: the last one wins. Epoch is 1 bit, so when redirect_in asserts with tags still in flight whose epoch is not current (a prior epoch), hold issue until the tag FIFO holds only current-epoch tags. The tag FIFO must therefore also count stale entries.
- busy_out = (state != RUN) | (in-flight count != 0).
- Reset asserted mid-operation: all state returns to reset values asynchronously. Responses arriving after reset deassertion with an empty tag FIFO are discarded.

Optional Feature:
FETCHQ_PERF_EN: when defined, the block adds:
- Output perf_issued (32), count of issued requests.
- Output perf_discarded (32), count of stale or orphan responses dropped.
- Output perf_hold_cycles (32), cycles spent in HOLD.
- All three reset to 0, saturate at 32'hFFFFFFFF, and are clocked on clk_in.
When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: FetchQEntry struct {pc[31:0], inst[31:0]}; FetchQTag struct {pc[31:0], epoch}; FSM enum FetchQState {BOOT, RUN, HOLD}.
- One sub-module, sync_fifo_ptr: parameterised width/depth FIFO with full/empty/count. Instantiated twice: entry queue and in-flight tag FIFO.

Test Plan:
- Reset release, memory latency 2, deq_in held 1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; out_pc 0x0 valid 3 cycles after the first request; one entry per cycle thereafter.
- deq_in=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_out=0 (HOLD); one dequeue -> exactly one new request the following cycle.
- Redirect to 0x100 with 2 responses in flight -> both discarded, out_valid=0, first new request addr 0x100; first entry out has out_pc=0x100.
- redirect_in and deq_in asserted together with 3 entries queued -> queue empty next cycle, no entry duplicated or skipped.
- Redirect to 32'hFFFFFFF8 -> requests FFFFFFF8, FFFFFFFC, 00000000; PCs wrap correctly.
- Reset asserted with 2 in flight and 3 queued -> outputs return to reset values immediately (asynchronously); subsequent orphan responses discarded; fetch restarts at RESET_PC.
